// File: rtl/sha256_stream_padder.sv
// SHA-256 front end: packs a byte stream into 512-bit blocks and appends the
// 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_stream_padder #(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*IN_BYTES-1:0]         in_data,
    input  logic                          in_last,
    input  logic [$clog2(IN_BYTES):0]     in_nbytes,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic [511:0]                  blk_data,
    output logic                          blk_first,
    output logic                          blk_last,
    output logic                          err
);
    localparam int NBW = $clog2(IN_BYTES) + 1;

    localparam logic [2:0] S_FILL      = 3'd0;
    localparam logic [2:0] S_PAD       = 3'd1;
    localparam logic [2:0] S_OUT_DATA  = 3'd2;
    localparam logic [2:0] S_OUT_PAD1  = 3'd3;
    localparam logic [2:0] S_OUT_FINAL = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [7:0]       buf_q [64];
    logic [7:0]       buf_d [64];
    logic [6:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             pad_owed_q, pad_owed_d;
    logic             err_q, err_d;

    logic             nb_over;
    logic [NBW-1:0]   nb_eff;
    logic [LEN_W:0]   sum;
    logic [6:0]       off;
    logic [63:0]      len64;
    logic [7:0]       len_byte [8];

    assign len64 = 64'(cnt_q);

    for (genvar g = 0; g < 8; g++) begin : g_len
        assign len_byte[g] = len64[63-8*g -: 8];
    end

    assign in_ready  = (state_q == S_FILL) && !reset;
    assign blk_valid = (state_q == S_OUT_DATA) || (state_q == S_OUT_PAD1) ||
                       (state_q == S_OUT_FINAL);
    assign blk_first = blk_valid && first_q;
    assign blk_last  = (state_q == S_OUT_FINAL);
    assign err       = err_q;

    for (genvar g = 0; g < 64; g++) begin : g_out
        assign blk_data[511-8*g -: 8] = blk_valid ? buf_q[g] : 8'h00;
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        pad_owed_d = pad_owed_q;
        err_d      = err_q;
        off        = '0;

        // Oversized last-beat counts are clamped; non-last beats are always full.
        nb_over = in_last && (in_nbytes > NBW'(IN_BYTES));
        nb_eff  = (!in_last || nb_over) ? NBW'(IN_BYTES) : in_nbytes;
        sum     = {1'b0, cnt_q} + (LEN_W+1)'({nb_eff, 3'b000});

        case (state_q)
            S_FILL: begin
                if (in_valid && in_ready) begin
                    for (int unsigned k = 0; k < 64; k++) begin
                        off = 7'(k) - ptr_q;
                        if ((7'(k) >= ptr_q) && (off < 7'(nb_eff))) begin
                            buf_d[6'(k)] = 8'(in_data >> (8 * (IN_BYTES - 1 - int'(off))));
                        end
                    end
                    ptr_d = ptr_q + 7'(nb_eff);
                    cnt_d = sum[LEN_W-1:0];
                    if (sum[LEN_W] || nb_over) begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_PAD;
                    end else if (ptr_d == 7'd64) begin
                        state_d = S_OUT_DATA;
                    end
                end
            end
            S_PAD: begin
                for (int unsigned k = 0; k < 64; k++) begin
                    if (7'(k) == ptr_q) begin
                        buf_d[6'(k)] = 8'h80;
                    end else if (7'(k) > ptr_q) begin
                        buf_d[6'(k)] = 8'h00;
                    end
                end
                if (ptr_q <= 7'd55) begin
                    for (int unsigned k = 0; k < 8; k++) begin
                        buf_d[6'(56 + k)] = len_byte[3'(k)];
                    end
                    state_d = S_OUT_FINAL;
                end else if (ptr_q < 7'd64) begin
                    state_d = S_OUT_PAD1;
                end else begin
                    pad_owed_d = 1'b1;
                    state_d    = S_OUT_DATA;
                end
            end
            S_OUT_DATA: begin
                if (blk_ready) begin
                    buf_d   = '{default: 8'h00};
                    ptr_d   = '0;
                    first_d = 1'b0;
                    if (pad_owed_q) begin
                        buf_d[0] = 8'h80;
                        for (int unsigned k = 0; k < 8; k++) begin
                            buf_d[6'(56 + k)] = len_byte[3'(k)];
                        end
                        pad_owed_d = 1'b0;
                        state_d    = S_OUT_FINAL;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_OUT_PAD1: begin
                if (blk_ready) begin
                    buf_d = '{default: 8'h00};
                    for (int unsigned k = 0; k < 8; k++) begin
                        buf_d[6'(56 + k)] = len_byte[3'(k)];
                    end
                    ptr_d   = '0;
                    first_d = 1'b0;
                    state_d = S_OUT_FINAL;
                end
            end
            S_OUT_FINAL: begin
                if (blk_ready) begin
                    buf_d   = '{default: 8'h00};
                    ptr_d   = '0;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FILL;
            buf_q      <= '{default: 8'h00};
            ptr_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            pad_owed_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            pad_owed_q <= pad_owed_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: random and directed messages compared
// against a byte-level FIPS 180-4 padding model.
module tb_sha256_stream_padder;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         err;

    int checks = 0;
    int failures = 0;
    logic [511:0] exp_blks[$];

    always #5 clk = ~clk;

    sha256_stream_padder #(.IN_BYTES(4), .LEN_W(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .err(err)
    );

    // Reference: pad the whole message as a byte list, then cut into 64-byte blocks.
    function automatic void model(input byte unsigned m[$]);
        byte unsigned p[$];
        longint unsigned bits;
        logic [511:0] blk;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 8;
        for (int j = 0; j < 8; j++) p.push_back(8'(bits >> (8 * (7 - j))));
        exp_blks.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int k = 0; k < 64; k++) blk = {blk[503:0], p[64*b+k]};
            exp_blks.push_back(blk);
        end
    endfunction

    task automatic drive_msg(input byte unsigned m[$], input int nbo);
        int n, sz, t;
        logic [31:0] d;
        bit acc, lastb;
        sz = m.size();
        n = (sz == 0) ? 1 : (sz + 3) / 4;
        for (int b = 0; b < n; b++) begin
            d = '0;
            for (int k = 0; k < 4; k++) begin
                int idx = 4 * b + k;
                d = {d[23:0], (idx < sz) ? m[idx] : 8'($urandom)};
            end
            lastb = (b == n - 1);
            in_data = d;
            in_last = lastb;
            in_nbytes = lastb ? 3'(sz - 4 * (n - 1)) : 3'($urandom_range(0, 7));
            if (lastb && nbo >= 0) in_nbytes = 3'(nbo);
            in_valid = 1'b1;
            t = 0;
            do begin
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end while (!acc && t < 500);
            in_valid = 1'b0;
            in_last = 1'b0;
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL beat_accept: beat %0d not accepted, got in_ready=0 want 1", b);
                return;
            end
            if (lastb) begin
                checks++;
                if (blk_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL last_beat_latency: blk_valid=%b one cycle after last beat, want 0", blk_valid);
                end
            end else if (((4 * (b + 1)) % 64) == 0) begin
                checks++;
                if (blk_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL full_block_latency: blk_valid=%b after 64th byte, want 1", blk_valid);
                end
            end
        end
    endtask

    task automatic collect(input int bp, input int len);
        int t, n;
        logic [511:0] sd;
        logic sf, sl;
        bit chained;
        n = exp_blks.size();
        for (int j = 0; j < n; j++) begin
            t = 0;
            while (!blk_valid && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (!blk_valid) begin
                failures++;
                $display("FAIL blk_timeout: block %0d never valid, got 0 want 1", j);
                return;
            end
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL in_ready_out: got %b want 0 while block %0d pending", in_ready, j);
            end
            checks++;
            if (blk_data !== exp_blks[j]) begin
                failures++;
                $display("FAIL blk_data[%0d]: got %h want %h", j, blk_data, exp_blks[j]);
            end
            checks++;
            if (blk_first !== (j == 0) || blk_last !== (j == n - 1)) begin
                failures++;
                $display("FAIL blk_flags[%0d]: got first=%b last=%b want first=%b last=%b",
                         j, blk_first, blk_last, j == 0, j == n - 1);
            end
            sd = blk_data; sf = blk_first; sl = blk_last;
            repeat (bp) begin
                @(posedge clk); #1;
                checks++;
                if ({blk_valid, blk_data, blk_first, blk_last, in_ready} !== {1'b1, sd, sf, sl, 1'b0}) begin
                    failures++;
                    $display("FAIL hold[%0d]: got v=%b f=%b l=%b rdy=%b data=%h want v=1 f=%b l=%b rdy=0 data=%h",
                             j, blk_valid, blk_first, blk_last, in_ready, blk_data, sf, sl, sd);
                end
            end
            blk_ready = 1'b1;
            @(posedge clk); #1;
            blk_ready = 1'b0;
            chained = (j == n - 2) && (((len % 64) >= 56) || ((len % 64) == 0));
            if (chained) begin
                checks++;
                if (blk_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL chain_latency: blk_valid=%b one cycle after block %0d, want 1", blk_valid, j);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL extra_block: blk_valid=%b after %0d blocks, want 0", blk_valid, n);
        end
    endtask

    task automatic run_msg(input byte unsigned m[$], input int bp);
        model(m);
        fork
            drive_msg(m, -1);
            collect(bp, m.size());
        join
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; blk_ready = 1'b0;
        in_data = '0; in_last = 1'b0; in_nbytes = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, blk_valid, blk_first, blk_last, err} !== 5'b0 || blk_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b v=%b f=%b l=%b err=%b data=%h want all 0",
                     in_ready, blk_valid, blk_first, blk_last, err, blk_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_abc;
        logic [511:0] want;
        int t;
        want = {8'h61, 8'h62, 8'h63, 8'h80, 416'h0, 64'h18};
        in_data = 32'h61626300; in_last = 1'b1; in_nbytes = 3'd3; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL abc_pad_cycle: blk_valid=%b want 0", blk_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({blk_valid, blk_first, blk_last} !== 3'b111 || blk_data !== want) begin
            failures++;
            $display("FAIL abc_block: got v=%b f=%b l=%b data=%h want v=1 f=1 l=1 data=%h",
                     blk_valid, blk_first, blk_last, blk_data, want);
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abc_done: got v=%b rdy=%b want v=0 rdy=1", blk_valid, in_ready);
        end
    endtask

    task automatic test_empty;
        byte unsigned m[$];
        run_msg(m, 0);
    endtask

    task automatic test_56(input int bp);
        byte unsigned m[$];
        for (int i = 0; i < 56; i++) m.push_back(8'h61);
        run_msg(m, bp);
    endtask

    task automatic test_64;
        byte unsigned m[$];
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        run_msg(m, 2);
    endtask

    task automatic test_random;
        byte unsigned m[$];
        int len;
        for (int r = 0; r < 8; r++) begin
            m.delete();
            len = $urandom_range(0, 150);
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            run_msg(m, $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back;
        byte unsigned m[$];
        for (int i = 0; i < 70; i++) m.push_back(8'($urandom));
        run_msg(m, 0);
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0);
    endtask

    task automatic test_reset_mid;
        byte unsigned m[$];
        in_valid = 1'b1; in_last = 1'b0; in_nbytes = 3'd4;
        repeat (5) begin
            in_data = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_hold: got rdy=%b v=%b want 0 0", in_ready, blk_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (blk_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_emit: blk_valid=%b want 0", blk_valid);
            end
        end
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0);
    endtask

    task automatic test_err;
        byte unsigned m[$];
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean: err=%b want 0", err);
        end
        m = '{8'h11, 8'h22, 8'h33, 8'h44};
        model(m);
        fork
            drive_msg(m, 5);
            collect(0, 4);
        join
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: err=%b want 1", err);
        end
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err=%b want 1", err);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: err=%b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_56(0);
        test_64();
        test_56(10);
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sha256_stream_padder.md
Name: sha256_stream_padder

Overview:
- Front end for the sha256 core. Accepts a message as a stream of IN_BYTES-wide beats and emits 512-bit blocks with SHA-256 padding applied.
- Padding per FIPS 180-4: data, then 0x80, then zero bytes, then the 64-bit big-endian bit length.
- Each emitted block goes out on a valid/ready port with first/last flags, so a sequencer can issue init or next to the core.
- Generalises the fixed hand-padded single-block flow to arbitrary-length, multi-block messages.

Parameters:
- IN_BYTES, 4, bytes per input beat. Legal values are 1, 2, 4 and 8, so every value divides 64.
- LEN_W, 64, width of the internal bit-length counter. It is zero-extended into the 64-bit length field.

Ports:
- clk  in  1  clock. Everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  padder can accept a beat.
- in_data  in  8*IN_BYTES  message bytes. The first byte is in bits [8*IN_BYTES-1 -: 8].
- in_last  in  1  beat is the final beat of the message.
- in_nbytes  in  $clog2(IN_BYTES)+1  number of valid bytes on a last beat, 0..IN_BYTES. Ignored on non-last beats, which are always full.
- blk_valid  out  1  output block valid.
- blk_ready  in  1  consumer accepts the block.
- blk_data  out  512  block. Message byte 0 is in [511:504].
- blk_first  out  1  block is the first of its message (use init).
- blk_last  out  1  block is the final, length-carrying block (digest valid after it).
- err  out  1  sticky error flag. Cleared only by reset.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; blk_valid=0, blk_data=0, blk_first=0, blk_last=0, err=0.
- Reset state: buffer cleared, byte pointer ptr=0, bit counter=0, first_pending=1, state=FILL.
- Reset while busy: the partial message or pending block is discarded. Nothing is emitted.
- State FILL (in_ready=1). A beat is accepted on in_valid&&in_ready:
  - Its valid bytes are written at buffer[ptr..].
  - ptr advances by IN_BYTES, or by in_nbytes on a last beat.
  - The bit counter advances by 8 times the bytes written.
- Non-last beat that brings ptr to 64: next state is OUT_DATA.
- Last beat: next state is PAD.
- PAD (1 cycle, in_ready=0). Let p = ptr after the last beat.
  - p<=55: write 0x80 at byte p, zero bytes p+1..55, write the length at bytes 56..63, go to OUT_FINAL.
  - 56<=p<=63: write 0x80 at byte p, zero the rest of the block, go to OUT_PAD1.
  - p==64: go to OUT_DATA with pad_owed=1.
- OUT_DATA (blk_valid=1, blk_last=0):
  - On handshake: clear the buffer and set ptr=0.
  - If pad_owed: build 0x80 at byte 0, zeros, and the length, then go to OUT_FINAL.
  - Else: return to FILL.
- OUT_PAD1 (blk_valid=1, blk_last=0): on handshake, build an all-zero block with the length in bytes 56..63, then go to OUT_FINAL.
- OUT_FINAL (blk_valid=1, blk_last=1): on handshake, clear everything, set first_pending=1, go to FILL.
- blk_first = first_pending during any OUT state. first_pending clears on the first block handshake.
- Latency:
  - Completing non-last beat to blk_valid: 1 cycle.
  - Last beat to blk_valid: 2 cycles (through PAD).
  - Block handshake to the next block's blk_valid, for chained pad blocks: 1 cycle.
- Backpressure: blk_data, blk_first and blk_last hold stable while blk_valid&&!blk_ready. in_ready=0 in every state except FILL.
- Length field: the bit counter is zero-extended to 64 bits and written big-endian.
- err is set on either of:
  - the bit counter wrapping past 2^LEN_W-1; the count wraps and processing continues;
  - in_nbytes>IN_BYTES on a last beat; the value is clamped to IN_BYTES.
- in_valid with in_ready=0 has no effect.

Test Plan:
- "abc", IN_BYTES=4: one last beat 0x61626300 with nbytes=3.
  - Exactly one block: 0x616263800…0018, first=1, last=1.
  - blk_valid 2 cycles after the beat.
- Empty message: a last beat with nbytes=0.
  - One block 0x8000…0000, first=1, last=1.
- 56-byte message of 0x61, sent as 14 beats.
  - Block 1: 56×0x61, then 0x80, then zeros; first=1, last=0.
  - Block 2: zeros with length 0x1C0; first=0, last=1.
- 64-byte message.
  - Block 1: pure data, last=0.
  - Block 2: 0x80 at byte 0 with length 0x200; last=1.
  - in_ready stays 0 until block 2 is accepted.
- Backpressure: hold blk_ready=0 for 10 cycles on each block of the 56-byte case.
  - Outputs stay stable and no beat is accepted.
  - Results are identical after release.
- Fault cases:
  - reset asserted mid-message: blk_valid=0, no block is emitted, and the next "abc" gives the correct single block.
  - nbytes=5 on a last beat with IN_BYTES=4: err=1 and stays 1 until reset.
